// File: rtl/ddr_native_app_model.sv
// On-chip RAM responder for the DDR native app_* interface.
// In-order executor, fixed read latency, optional ready stalls.
module ddr_native_app_model #(
  parameter int ADDR_WIDTH   = 27,
  parameter int DATA_WIDTH   = 256,
  parameter int MEM_AW       = 10,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 8,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete,
  input  logic                    rdy_stall_en,
  output logic [1:0]              err_flags
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int WAW = $clog2(WDF_DEPTH);
  localparam int CCW = $clog2(CALIB_CYCLES + 1);
  localparam logic [CAW:0] CQ_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [WAW:0] WQ_FULL = (WAW+1)'(WDF_DEPTH);
  localparam logic [CCW-1:0] CAL_LAST = CCW'(CALIB_CYCLES - 1);

  logic            calib;
  logic [CCW-1:0]  cal_cnt;
  logic [15:0]     lfsr;

  logic [2:0]        cq_op  [CMD_DEPTH];
  logic [MEM_AW-1:0] cq_idx [CMD_DEPTH];
  logic [CAW:0]      cq_wp, cq_rp, cq_cnt;

  logic [DATA_WIDTH-1:0] wq_data [WDF_DEPTH];
  logic [NB-1:0]         wq_mask [WDF_DEPTH];
  logic [WAW:0]          wq_wp, wq_rp, wq_cnt;

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic [DATA_WIDTH-1:0] pd [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv;

  logic cq_full, cq_empty, wq_full, wq_empty;
  logic cmd_push, wdf_push;
  logic ex_wr, ex_rd, ex_ill;
  logic [2:0]            h_op;
  logic [MEM_AW-1:0]     h_idx;
  logic [DATA_WIDTH-1:0] h_data;
  logic [NB-1:0]         h_mask;
  logic                  lfsr_fb;
  logic                  unused_addr;

  assign unused_addr = ^{app_addr[ADDR_WIDTH-1:3+MEM_AW],
                         app_addr[2:0]};

  assign cq_cnt   = cq_wp - cq_rp;
  assign wq_cnt   = wq_wp - wq_rp;
  assign cq_full  = (cq_cnt == CQ_FULL);
  assign wq_full  = (wq_cnt == WQ_FULL);
  assign cq_empty = (cq_wp == cq_rp);
  assign wq_empty = (wq_wp == wq_rp);

  assign app_rdy = calib && !cq_full &&
                   !(rdy_stall_en && lfsr[0]);
  assign app_wdf_rdy = calib && !wq_full;

  assign cmd_push = app_en && app_rdy;
  assign wdf_push = app_wdf_wren && app_wdf_rdy;

  assign h_op   = cq_op[cq_rp[CAW-1:0]];
  assign h_idx  = cq_idx[cq_rp[CAW-1:0]];
  assign h_data = wq_data[wq_rp[WAW-1:0]];
  assign h_mask = wq_mask[wq_rp[WAW-1:0]];

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign init_calib_complete = calib;
  assign app_rd_data         = pd[RD_LATENCY-1];
  assign app_rd_data_valid   = pv[RD_LATENCY-1];
  assign app_rd_data_end     = pv[RD_LATENCY-1];

  // A write at the head blocks the queue until its data arrives.
  always_comb begin
    ex_wr  = 1'b0;
    ex_rd  = 1'b0;
    ex_ill = 1'b0;
    if (!cq_empty) begin
      unique case (1'b1)
        (h_op == 3'b000): ex_wr  = !wq_empty;
        (h_op == 3'b001): ex_rd  = 1'b1;
        default:          ex_ill = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      calib     <= 1'b0;
      cal_cnt   <= '0;
      lfsr      <= 16'hACE1;
      cq_wp     <= '0;
      cq_rp     <= '0;
      wq_wp     <= '0;
      wq_rp     <= '0;
      err_flags <= 2'b00;
      pv        <= '0;
      for (int i = 0; i < RD_LATENCY; i++)
        pd[i] <= '0;
    end else begin
      if (!calib) begin
        cal_cnt <= cal_cnt + 1'b1;
        if (cal_cnt == CAL_LAST)
          calib <= 1'b1;
      end else begin
        lfsr <= {lfsr[14:0], lfsr_fb};
      end
      if (cmd_push)
        cq_wp <= cq_wp + 1'b1;
      if (ex_wr || ex_rd || ex_ill)
        cq_rp <= cq_rp + 1'b1;
      if (wdf_push)
        wq_wp <= wq_wp + 1'b1;
      if (ex_wr)
        wq_rp <= wq_rp + 1'b1;
      if (ex_ill)
        err_flags[0] <= 1'b1;
      if (app_wdf_wren && !app_wdf_end)
        err_flags[1] <= 1'b1;
      pv[0] <= ex_rd;
      pd[0] <= ex_rd ? mem[h_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (cmd_push) begin
      cq_op[cq_wp[CAW-1:0]]  <= app_cmd;
      cq_idx[cq_wp[CAW-1:0]] <= app_addr[3+MEM_AW-1:3];
    end
    if (wdf_push) begin
      wq_data[wq_wp[WAW-1:0]] <= app_wdf_data;
      wq_mask[wq_wp[WAW-1:0]] <= app_wdf_mask;
    end
  end

  // Contents survive reset, as a real DRAM would.
  always_ff @(posedge clock) begin
    if (ex_wr) begin
      for (int b = 0; b < NB; b++)
        if (!h_mask[b])
          mem[h_idx][b*8 +: 8] <= h_data[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_ddr_native_app_model.sv
// Directed bench for ddr_native_app_model.
// Vector table plus hand-written multi-cycle sequences.
module tb_ddr_native_app_model;

  logic         clock = 1'b0;
  logic         rst_n;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         rdy_stall_en;
  logic [1:0]   err_flags;

  ddr_native_app_model dut (
    .clock(clock),
    .rst_n(rst_n),
    .app_addr(app_addr),
    .app_cmd(app_cmd),
    .app_en(app_en),
    .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .init_calib_complete(init_calib_complete),
    .rdy_stall_en(rdy_stall_en),
    .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int stalls = 0;
  logic [255:0] rd_q [$];
  int           rd_cyc [$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (app_rd_data_valid) begin
      rd_q.push_back(app_rd_data);
      rd_cyc.push_back(cyc);
      n_chk++;
      if (app_rd_data_end !== 1'b1) begin
        n_fail++;
        $display("FAIL rd_end: got %b expected 1",
                 app_rd_data_end);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic send_cmd(input logic [2:0] c,
                          input logic [26:0] a);
    bit done = 0;
    app_cmd  = c;
    app_addr = a;
    app_en   = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (app_rdy) done = 1;
      else stalls++;
      tick();
    end
    app_en  = 1'b0;
    acc_cyc = cyc;
    if (!done) timeout("cmd_accept");
  endtask

  task automatic send_data(input logic [255:0] d,
                           input logic [31:0] m);
    bit done = 0;
    app_wdf_data = d;
    app_wdf_mask = m;
    app_wdf_end  = 1'b1;
    app_wdf_wren = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (app_wdf_rdy) done = 1;
      tick();
    end
    app_wdf_wren = 1'b0;
    if (!done) timeout("wdf_accept");
  endtask

  task automatic do_write(input logic [26:0] a,
                          input logic [255:0] d,
                          input logic [31:0] m);
    fork
      send_cmd(3'b000, a);
      send_data(d, m);
    join
  endtask

  task automatic get_read(output logic [255:0] d,
                          output int lat);
    int n = 0;
    while (rd_q.size() == 0 && n < 64) begin
      tick();
      n++;
    end
    if (rd_q.size() == 0) begin
      timeout("rd_return");
      d   = '0;
      lat = -1;
    end else begin
      d   = rd_q.pop_front();
      lat = rd_cyc.pop_front() - acc_cyc;
    end
  endtask

  function automatic logic [255:0] pat(int k);
    return {8{32'h11110000 + 32'(k)}};
  endfunction

  typedef struct {
    bit           rd;
    logic [26:0]  addr;
    logic [255:0] data;
    logic [31:0]  mask;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [255:0] d, e;
    logic [26:0]  a;
    int           lat, acc, r;
    logic [255:0] model [int];
    int           wl [$];

    tbl[0]  = '{0, 27'h40,   {32{8'hA5}},  32'h0, '0};
    tbl[1]  = '{1, 27'h40,   '0, 32'h0, {32{8'hA5}}};
    tbl[2]  = '{0, 27'h80,   {256{1'b1}},  32'h0, '0};
    tbl[3]  = '{0, 27'h80,   '0, 32'h1, '0};
    tbl[4]  = '{1, 27'h80,   '0, 32'h0, {248'h0, 8'hFF}};
    tbl[5]  = '{0, 27'h2040, {32{8'h3C}},  32'hFFFF0000, '0};
    tbl[6]  = '{1, 27'h40,   '0, 32'h0,
                {{16{8'hA5}}, {16{8'h3C}}}};
    tbl[7]  = '{1, 27'h47,   '0, 32'h0,
                {{16{8'hA5}}, {16{8'h3C}}}};
    tbl[8]  = '{0, 27'h1FF8, {16{16'hBEEF}}, 32'h0, '0};
    tbl[9]  = '{1, 27'h1FF8, '0, 32'h0, {16{16'hBEEF}}};
    tbl[10] = '{0, 27'h0, {8{32'hDEADBEEF}}, 32'h0, '0};
    tbl[11] = '{1, 27'h2000, '0, 32'h0, {8{32'hDEADBEEF}}};

    rst_n = 1'b0;
    app_addr = '0;
    app_cmd = '0;
    app_en = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b1;
    rdy_stall_en = 1'b0;
    repeat (3) tick();
    check("rst_rdy", app_rdy, 0);
    check("rst_wdf_rdy", app_wdf_rdy, 0);
    check("rst_calib", init_calib_complete, 0);
    check("rst_valid", app_rd_data_valid, 0);
    check("rst_data", app_rd_data, 0);
    check("rst_err", err_flags, 0);

    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) check("calib_15", init_calib_complete, 0);
      if (i == 16) begin
        check("calib_16", init_calib_complete, 1);
        check("rdy_16", app_rdy, 1);
        check("wdf_rdy_16", app_wdf_rdy, 1);
      end
    end

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rd) begin
        send_cmd(3'b001, tbl[i].addr);
        get_read(d, lat);
        check($sformatf("tbl%0d_data", i), d, tbl[i].exp);
        check($sformatf("tbl%0d_lat", i), lat, 4);
      end else begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
      end
    end

    acc = 0;
    for (int c = 0; c < 10; c++) begin
      app_cmd  = 3'b000;
      app_addr = 27'h100 + 27'(acc * 8);
      app_en   = 1'b1;
      if (app_rdy) begin
        tick();
        acc++;
      end else begin
        tick();
      end
    end
    app_en = 1'b0;
    check("bp_accepted", acc, 4);
    check("bp_rdy_low", app_rdy, 0);
    fork
      begin
        for (int k = acc; k < 8; k++)
          send_cmd(3'b000, 27'h100 + 27'(k * 8));
      end
      begin
        for (int k = 0; k < 8; k++)
          send_data(pat(k), 32'h0);
      end
    join
    repeat (10) tick();
    for (int k = 0; k < 8; k++) begin
      send_cmd(3'b001, 27'h100 + 27'(k * 8));
      get_read(d, lat);
      check($sformatf("bp_rd%0d", k), d, pat(k));
    end

    rdy_stall_en = 1'b1;
    stalls = 0;
    for (int p = 0; p < 64; p++) begin
      a = 27'($urandom);
      a[12:3] = 10'($urandom_range(32, 47));
      for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
      do_write(a, d, 32'h0);
      if (!model.exists(int'(a[12:3]))) wl.push_back(int'(a[12:3]));
      model[int'(a[12:3])] = d;
      r = wl[$urandom_range(0, wl.size() - 1)];
      a = 27'($urandom);
      a[12:3] = 10'(r);
      send_cmd(3'b001, a);
      get_read(e, lat);
      check($sformatf("rnd_rd%0d", p), e, model[r]);
    end
    check("stall_seen", stalls > 0, 1);
    rdy_stall_en = 1'b0;

    rd_q.delete();
    rd_cyc.delete();
    send_cmd(3'b011, 27'h40);
    repeat (12) tick();
    check("ill_err", err_flags, 2'b01);
    check("ill_no_read", rd_q.size(), 0);
    app_wdf_end  = 1'b0;
    app_wdf_wren = 1'b1;
    tick();
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b1;
    tick();
    check("wdf_end_err", err_flags, 2'b11);

    send_cmd(3'b001, 27'h40);
    send_cmd(3'b001, 27'h80);
    send_cmd(3'b001, 27'h1FF8);
    rst_n = 1'b0;
    repeat (2) tick();
    check("mid_rst_rdy", app_rdy, 0);
    check("mid_rst_calib", init_calib_complete, 0);
    check("mid_rst_err", err_flags, 0);
    check("mid_rst_valid", app_rd_data_valid, 0);
    rst_n = 1'b1;
    repeat (30) tick();
    check("mid_rst_no_read", rd_q.size(), 0);
    check("recal", init_calib_complete, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
